// File: rtl/vga_timing_monitor.sv
// Passive checker for a VGA pixel stream: rebuilds hcount/vcount from the sync
// edges, locks after two well-formed frames and records sticky timing/blanking errors.
module vga_timing_monitor #(
   parameter int H_TOTAL    = 1344,
   parameter int H_SYNC_ST  = 1048,
   parameter int H_SYNC_LEN = 136,
   parameter int V_TOTAL    = 806,
   parameter int V_SYNC_ST  = 771,
   parameter int V_SYNC_LEN = 6
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        err_clr,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   output logic [10:0] hcount_rec,
   output logic [10:0] vcount_rec,
   output logic        locked,
   output logic [3:0]  err_flags,
   output logic [7:0]  err_cnt,
   output logic [15:0] frame_cnt
);

   typedef enum logic [1:0] {SEARCH = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_t;

   localparam logic [10:0] H_TOT  = 11'(H_TOTAL);
   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ST   = 11'(H_SYNC_ST);
   localparam logic [10:0] H_TAIL = 11'(H_TOTAL - H_SYNC_ST);
   localparam logic [10:0] H_LEN  = 11'(H_SYNC_LEN);
   localparam logic [10:0] V_ST   = 11'(V_SYNC_ST);
   localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
   localparam logic [9:0]  L_TOT  = 10'(V_TOTAL);
   localparam logic [9:0]  L_VLEN = 10'(V_SYNC_LEN);

   state_t      state_q, state_d;
   logic        hsync_prev_q, vsync_prev_q;
   logic [10:0] h_meas_q, h_meas_d;
   logic [9:0]  line_cnt_q, line_cnt_d;
   logic [10:0] hs_width_q, hs_width_d;
   logic [10:0] vcount_q, vcount_d;
   logic        hs_seen_q, hs_seen_d;
   logic        frame_bad_q, frame_bad_d;
   logic [1:0]  frame_ok_q, frame_ok_d;
   logic [10:0] hcount_rec_q, hcount_rec_d;
   logic [10:0] vcount_rec_q, vcount_rec_d;
   logic [3:0]  err_flags_q, err_flags_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   logic        hs_rise, vs_rise, hs_fall, vs_fall;
   logic        line_bad, frame_good;
   logic [10:0] h_mod, hcount_cur;
   logic [3:0]  err_vec;

   assign hs_rise = hsync_in & ~hsync_prev_q;
   assign vs_rise = vsync_in & ~vsync_prev_q;
   assign hs_fall = ~hsync_in & hsync_prev_q;
   assign vs_fall = ~vsync_in & vsync_prev_q;

   // h_meas is zero on the hsync-rise sample, i.e. the sample whose hcount is H_SYNC_ST.
   always_comb begin
      h_meas_d = h_meas_q;
      if (hs_rise) begin
         h_meas_d = 11'd0;
      end else if (h_meas_q != 11'h7ff) begin
         h_meas_d = h_meas_q + 11'd1;
      end
      h_mod      = (h_meas_d >= H_TAIL) ? (h_meas_d - H_TAIL) : (h_meas_d + H_ST);
      hcount_cur = (h_mod >= H_TOT) ? (h_mod - H_TOT) : h_mod;

      vcount_d = vcount_q;
      if (vs_rise) begin
         vcount_d = V_ST;
      end else if (hcount_cur == 11'd0) begin
         vcount_d = (vcount_q >= V_LAST) ? 11'd0 : (vcount_q + 11'd1);
      end

      line_cnt_d = line_cnt_q;
      if (vs_rise) begin
         line_cnt_d = 10'd0;
      end else if (hs_rise && (line_cnt_q != 10'h3ff)) begin
         line_cnt_d = line_cnt_q + 10'd1;
      end

      hs_width_d = hs_width_q;
      if (hs_rise) begin
         hs_width_d = 11'd1;
      end else if (hsync_in && (hs_width_q != 11'h7ff)) begin
         hs_width_d = hs_width_q + 11'd1;
      end

      hs_seen_d   = hs_seen_q | hs_rise;
      line_bad    = hs_rise & hs_seen_q & (h_meas_q != H_LAST);
      frame_bad_d = vs_rise ? 1'b0 : (frame_bad_q | line_bad);
      frame_good  = ~frame_bad_q & (line_cnt_q == L_TOT);
   end

   // Error detection, lock FSM and the registered views of the recovered counters.
   always_comb begin
      err_vec = 4'b0000;
      if (state_q == LOCKED) begin
         err_vec[0] = line_bad | (~hs_rise & (h_meas_q == 11'h7fe));
         err_vec[1] = hs_fall & (hs_width_q != H_LEN);
         err_vec[2] = vs_fall & (line_cnt_q != L_VLEN);
         err_vec[3] = (hblnk_in | vblnk_in) & (rgb_in != 12'h000);
      end

      state_d    = state_q;
      frame_ok_d = frame_ok_q;
      case (state_q)
         SEARCH: begin
            if (vs_rise) begin
               state_d    = ALIGN;
               frame_ok_d = 2'd0;
            end
         end
         ALIGN: begin
            if (vs_rise) begin
               if (!frame_good) begin
                  frame_ok_d = 2'd0;
               end else if (frame_ok_q == 2'd1) begin
                  frame_ok_d = 2'd2;
                  state_d    = LOCKED;
               end else begin
                  frame_ok_d = frame_ok_q + 2'd1;
               end
            end
         end
         LOCKED: begin
            if (|err_vec[2:0]) begin
               state_d = SEARCH;
            end
         end
         default: state_d = SEARCH;
      endcase

      frame_cnt_d = frame_cnt_q;
      if ((state_q == LOCKED) && vs_rise) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end

      err_flags_d = err_flags_q | err_vec;
      err_cnt_d   = err_cnt_q;
      if (err_clr) begin
         err_flags_d = err_vec;
         err_cnt_d   = {7'd0, |err_vec};
      end else if ((|err_vec) && (err_cnt_q != 8'hff)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end

      hcount_rec_d = 11'd0;
      vcount_rec_d = 11'd0;
      if (state_d == LOCKED) begin
         hcount_rec_d = hcount_cur;
         vcount_rec_d = vcount_d;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q      <= SEARCH;
         hsync_prev_q <= 1'b0;
         vsync_prev_q <= 1'b0;
         h_meas_q     <= 11'd0;
         line_cnt_q   <= 10'd0;
         hs_width_q   <= 11'd0;
         vcount_q     <= 11'd0;
         hs_seen_q    <= 1'b0;
         frame_bad_q  <= 1'b0;
         frame_ok_q   <= 2'd0;
         hcount_rec_q <= 11'd0;
         vcount_rec_q <= 11'd0;
         err_flags_q  <= 4'd0;
         err_cnt_q    <= 8'd0;
         frame_cnt_q  <= 16'd0;
      end else begin
         state_q      <= state_d;
         hsync_prev_q <= hsync_in;
         vsync_prev_q <= vsync_in;
         h_meas_q     <= h_meas_d;
         line_cnt_q   <= line_cnt_d;
         hs_width_q   <= hs_width_d;
         vcount_q     <= vcount_d;
         hs_seen_q    <= hs_seen_d;
         frame_bad_q  <= frame_bad_d;
         frame_ok_q   <= frame_ok_d;
         hcount_rec_q <= hcount_rec_d;
         vcount_rec_q <= vcount_rec_d;
         err_flags_q  <= err_flags_d;
         err_cnt_q    <= err_cnt_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign hcount_rec = hcount_rec_q;
   assign vcount_rec = vcount_rec_q;
   assign locked     = (state_q == LOCKED);
   assign err_flags  = err_flags_q;
   assign err_cnt    = err_cnt_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor on a shrunken raster; a source generator drives the
// stream and queues the expected lock/counter outputs for every sample it drives.
module tb_vga_timing_monitor;

   localparam int HT = 40;
   localparam int HS = 34;
   localparam int HL = 4;
   localparam int HA = 32;
   localparam int VT = 14;
   localparam int VS = 10;
   localparam int VL = 2;
   localparam int VA = 9;
   localparam int FRAME = HT * VT;

   logic        pclk;
   logic        rst;
   logic        err_clr;
   logic        hsync_in;
   logic        vsync_in;
   logic        hblnk_in;
   logic        vblnk_in;
   logic [11:0] rgb_in;
   logic [10:0] hcount_rec;
   logic [10:0] vcount_rec;
   logic        locked;
   logic [3:0]  err_flags;
   logic [7:0]  err_cnt;
   logic [15:0] frame_cnt;

   vga_timing_monitor #(
      .H_TOTAL(HT), .H_SYNC_ST(HS), .H_SYNC_LEN(HL),
      .V_TOTAL(VT), .V_SYNC_ST(VS), .V_SYNC_LEN(VL)
   ) dut (
      .pclk(pclk), .rst(rst), .err_clr(err_clr),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
      .hcount_rec(hcount_rec), .vcount_rec(vcount_rec), .locked(locked),
      .err_flags(err_flags), .err_cnt(err_cnt), .frame_cnt(frame_cnt)
   );

   typedef struct {
      logic        lockedE;
      logic        countsE;
      logic [10:0] hcE;
      logic [10:0] vcE;
      logic [15:0] frE;
   } exp_t;

   exp_t sbQ[$];
   int   testsRun = 0;
   int   testsFailed = 0;

   // Source raster position and injection knobs
   int   hc = 0;
   int   vc = 0;
   logic stretchArm = 0, stretchLine = 0, shortArm = 0, shortLine = 0;
   logic blankArm = 0, clrWithBlank = 0, rstNow = 0, clrNow = 0;
   logic pendingLenErr = 0;
   logic prevHs = 0, prevVs = 0;

   // Expected lock behaviour derived from the generated stream
   logic        lockedExp = 0;
   logic        countsValid = 0;
   int          vsCount = 0;
   logic [15:0] framesExp = 0;

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Drive one raster sample and queue what the monitor should show after the edge.
   task automatic applyStimulus();
      logic        hs, vs, hb, vb, terr, isVsRise;
      logic [11:0] rgb;
      exp_t        e;
      if (hc == 0) begin
         stretchLine = stretchArm;
         shortLine   = shortArm;
         stretchArm  = 0;
         shortArm    = 0;
      end
      hs  = (hc >= HS) && (hc < HS + HL) && !(shortLine && (hc == HS + HL - 1));
      vs  = (vc >= VS) && (vc < VS + VL);
      hb  = (hc >= HA);
      vb  = (vc >= VA);
      rgb = (hb || vb) ? 12'h000 : 12'($urandom_range(1, 4095));
      err_clr = clrNow;
      if (blankArm && (hc == HA + 1)) begin
         rgb      = 12'hf00;
         blankArm = 0;
         if (clrWithBlank) begin
            err_clr      = 1'b1;
            clrWithBlank = 0;
         end
      end
      terr = 0;
      if (pendingLenErr && hs && !prevHs) begin
         terr          = 1;
         pendingLenErr = 0;
      end
      if (shortLine && (hc == HS + HL - 1)) terr = 1;
      if (hc == HT) countsValid = 0;
      isVsRise = vs && !prevVs && !rstNow;

      rst      = rstNow;
      hsync_in = hs;
      vsync_in = vs;
      hblnk_in = hb;
      vblnk_in = vb;
      rgb_in   = rgb;

      if (rstNow) begin
         lockedExp = 0;
         vsCount   = 0;
         framesExp = 0;
      end else if (lockedExp && terr) begin
         lockedExp = 0;
         vsCount   = 0;
      end else if (isVsRise) begin
         if (lockedExp) begin
            framesExp = framesExp + 16'd1;
         end else begin
            vsCount++;
            if (vsCount == 3) begin
               lockedExp   = 1;
               countsValid = 1;
            end
         end
      end
      e.lockedE = lockedExp;
      e.countsE = countsValid;
      e.hcE     = 11'(hc);
      e.vcE     = 11'(vc);
      e.frE     = framesExp;
      sbQ.push_back(e);

      prevHs = rstNow ? 1'b0 : hs;
      prevVs = rstNow ? 1'b0 : vs;
      if ((stretchLine && (hc == HT)) || (!stretchLine && (hc == HT - 1))) begin
         if (stretchLine) pendingLenErr = 1;
         stretchLine = 0;
         shortLine   = 0;
         hc = 0;
         vc = (vc + 1) % VT;
      end else begin
         hc++;
      end
      rstNow = 0;
      clrNow = 0;
   endtask

   task automatic checkScoreboard();
      exp_t e;
      if (sbQ.size() != 0) begin
         e = sbQ.pop_front();
         checkOutput("locked", 32'(locked), 32'(e.lockedE));
         checkOutput("frame_cnt", 32'(frame_cnt), 32'(e.frE));
         if (!e.lockedE) begin
            checkOutput("hcount_hold0", 32'(hcount_rec), 32'd0);
            checkOutput("vcount_hold0", 32'(vcount_rec), 32'd0);
         end else if (e.countsE) begin
            checkOutput("hcount_rec", 32'(hcount_rec), 32'(e.hcE));
            checkOutput("vcount_rec", 32'(vcount_rec), 32'(e.vcE));
         end
      end
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus();
         @(posedge pclk);
         #1;
         checkScoreboard();
      end
   endtask

   task automatic runUntil(input int vT, input int hT);
      int guard = 0;
      while (!((hc == hT) && (vc == vT)) && (guard < 2 * FRAME)) begin
         runCycles(1);
         guard++;
      end
   endtask

   initial begin
      rst = 1; err_clr = 0; hsync_in = 0; vsync_in = 0;
      hblnk_in = 0; vblnk_in = 0; rgb_in = 12'h000;

      // Reset state, then a nominal stream long enough to lock and run locked
      rstNow = 1;
      runCycles(1);
      checkOutput("rst_locked", 32'(locked), 32'd0);
      checkOutput("rst_err_flags", 32'(err_flags), 32'd0);
      checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
      checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      runCycles(6 * FRAME);
      checkOutput("nominal_err_flags", 32'(err_flags), 32'd0);
      checkOutput("nominal_err_cnt", 32'(err_cnt), 32'd0);

      // One stretched line while locked
      runUntil(5, 0);
      stretchArm = 1;
      runCycles(4 * FRAME);
      checkOutput("stretch_err_flags", 32'(err_flags), 32'b0001);
      checkOutput("stretch_err_cnt", 32'(err_cnt), 32'd1);

      // Shortened hsync pulse
      clrNow = 1;
      runCycles(1);
      checkOutput("clr_err_flags", 32'(err_flags), 32'd0);
      checkOutput("clr_err_cnt", 32'(err_cnt), 32'd0);
      runUntil(5, 0);
      shortArm = 1;
      runCycles(4 * FRAME);
      checkOutput("short_err_flag1", 32'(err_flags[1]), 32'd1);
      checkOutput("short_err_cnt", 32'(err_cnt), 32'd1);

      // Colour inside horizontal blanking keeps lock
      clrNow = 1;
      runCycles(1);
      runUntil(3, 0);
      blankArm = 1;
      runCycles(60);
      checkOutput("blank_err_flags", 32'(err_flags), 32'b1000);
      checkOutput("blank_err_cnt", 32'(err_cnt), 32'd1);
      checkOutput("blank_locked", 32'(locked), 32'd1);

      // Build up 4'b0011, then clear in the same cycle as a blank error
      clrNow = 1;
      runCycles(1);
      runUntil(5, 0);
      stretchArm = 1;
      runCycles(4 * FRAME);
      runUntil(5, 0);
      shortArm = 1;
      runCycles(4 * FRAME);
      checkOutput("pre_clr_err_flags", 32'(err_flags), 32'b0011);
      checkOutput("pre_clr_err_cnt", 32'(err_cnt), 32'd2);
      runUntil(3, 0);
      blankArm = 1;
      clrWithBlank = 1;
      runCycles(60);
      checkOutput("clr_vs_err_flags", 32'(err_flags), 32'b1000);
      checkOutput("clr_vs_err_cnt", 32'(err_cnt), 32'd1);

      // Reset mid-frame while locked, then relock and restart the frame count
      runUntil(5, 0);
      rstNow = 1;
      runCycles(1);
      checkOutput("midrst_err_flags", 32'(err_flags), 32'd0);
      checkOutput("midrst_err_cnt", 32'(err_cnt), 32'd0);
      checkOutput("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
      runCycles(4 * FRAME);
      checkOutput("relock_frame_cnt", 32'(frame_cnt), 32'd1);
      checkOutput("relock_locked", 32'(locked), 32'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
